// File: rtl/ai_sequencer_pkg.sv
// Shared types and constants for the AI-move sequencer and its Avalon-MM bus master.
package ai_sequencer_pkg;

    localparam int unsigned BoardCells = 100;
    localparam int unsigned IndexW     = 7;
    localparam int unsigned ShipsW     = 5;
    localparam int unsigned AddrW      = 3;
    localparam int unsigned DataW      = 64;

    // Accelerator slave register map.
    localparam logic [AddrW-1:0] AddrCtrl   = 3'd0;
    localparam logic [AddrW-1:0] AddrFired0 = 3'd1;
    localparam logic [AddrW-1:0] AddrFired1 = 3'd2;
    localparam logic [AddrW-1:0] AddrShips  = 3'd3;
    localparam logic [AddrW-1:0] AddrResult = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StWrF0,
        StWrF1,
        StWrShip,
        StWrStart,
        StPoll,
        StRdRes,
        StResp
    } seq_state_e;

    function automatic logic index_in_range(input logic [IndexW-1:0] idx);
        return idx < IndexW'(BoardCells);
    endfunction

endpackage

// File: rtl/ai_bus_master.sv
// Single-transfer Avalon-MM master: runs one read or write per request and aborts it
// once the slave has stalled for STALL_MAX consecutive cycles.
module ai_bus_master
    import ai_sequencer_pkg::*;
#(
    parameter int unsigned STALL_MAX = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             xfer_req,
    input  logic             xfer_write,
    input  logic [AddrW-1:0] xfer_addr,
    input  logic [DataW-1:0] xfer_wdata,
    output logic             xfer_done,
    output logic             xfer_abort,
    output logic [AddrW-1:0] ai_addr,
    output logic             ai_write,
    output logic             ai_read,
    output logic [DataW-1:0] ai_wdata,
    input  logic             ai_waitrequest
);

    localparam int unsigned StallW = $clog2(STALL_MAX + 1);

    logic [StallW-1:0] stall_cnt_q, stall_cnt_d;
    logic              rd_arm_q, rd_arm_d;
    logic              cmd;
    logic              stalled;

    // Reads are armed one cycle after being requested, so consecutive reads are always
    // separated by an idle bus cycle.
    assign cmd        = xfer_req && (xfer_write || rd_arm_q);
    assign stalled    = cmd && ai_waitrequest;
    assign xfer_done  = cmd && !ai_waitrequest;
    assign xfer_abort = stalled && (stall_cnt_q == StallW'(STALL_MAX - 1));

    assign ai_write = cmd && xfer_write;
    assign ai_read  = cmd && !xfer_write;
    assign ai_addr  = cmd ? xfer_addr : '0;
    assign ai_wdata = ai_write ? xfer_wdata : '0;

    always_comb begin
        stall_cnt_d = '0;
        if (stalled && !xfer_abort) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        rd_arm_d = xfer_req && !xfer_write && !xfer_done && !xfer_abort;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            rd_arm_q    <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            rd_arm_q    <= rd_arm_d;
        end
    end

endmodule

// File: rtl/ai_sequencer.sv
// Drives one AI move request through the accelerator: load board, start, poll for done,
// read the chosen cell and hand it to the game logic with an error flag.
module ai_sequencer
    import ai_sequencer_pkg::*;
#(
    parameter int unsigned STALL_MAX = 255,
    parameter int unsigned POLL_MAX  = 4095
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [BoardCells-1:0] fired_in,
    input  logic [ShipsW-1:0]     ships_in,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IndexW-1:0]     res_index,
    output logic                  res_error,
    output logic [AddrW-1:0]      ai_addr,
    output logic                  ai_write,
    output logic                  ai_read,
    output logic [DataW-1:0]      ai_wdata,
    input  logic                  ai_waitrequest,
    input  logic [DataW-1:0]      ai_rdata
);

    localparam int unsigned PollW = $clog2(POLL_MAX + 1);

    seq_state_e            state_q, state_d;
    logic [BoardCells-1:0] fired_q;
    logic [ShipsW-1:0]     ships_q;
    logic [PollW-1:0]      poll_cnt_q;
    logic [IndexW-1:0]     res_index_q;
    logic                  res_error_q;

    logic             xfer_req, xfer_write, xfer_done, xfer_abort;
    logic [AddrW-1:0] xfer_addr;
    logic [DataW-1:0] xfer_wdata;
    logic             accept, poll_done, poll_limit, result_ok;

    assign accept     = req_valid && req_ready;
    assign poll_done  = ai_rdata[0];
    assign poll_limit = (poll_cnt_q == PollW'(POLL_MAX - 1));
    assign result_ok  = index_in_range(ai_rdata[IndexW-1:0]);

    assign res_index = res_index_q;
    assign res_error = res_error_q;

    ai_bus_master #(
        .STALL_MAX (STALL_MAX)
    ) u_bus_master (
        .clock          (clock),
        .reset          (reset),
        .xfer_req       (xfer_req),
        .xfer_write     (xfer_write),
        .xfer_addr      (xfer_addr),
        .xfer_wdata     (xfer_wdata),
        .xfer_done      (xfer_done),
        .xfer_abort     (xfer_abort),
        .ai_addr        (ai_addr),
        .ai_write       (ai_write),
        .ai_read        (ai_read),
        .ai_wdata       (ai_wdata),
        .ai_waitrequest (ai_waitrequest)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) state_d = StWrF0;
            end
            StWrF0: begin
                if (xfer_abort)     state_d = StResp;
                else if (xfer_done) state_d = StWrF1;
            end
            StWrF1: begin
                if (xfer_abort)     state_d = StResp;
                else if (xfer_done) state_d = StWrShip;
            end
            StWrShip: begin
                if (xfer_abort)     state_d = StResp;
                else if (xfer_done) state_d = StWrStart;
            end
            StWrStart: begin
                if (xfer_abort)     state_d = StResp;
                else if (xfer_done) state_d = StPoll;
            end
            StPoll: begin
                if (xfer_abort) begin
                    state_d = StResp;
                end else if (xfer_done) begin
                    if (poll_done)       state_d = StRdRes;
                    else if (poll_limit) state_d = StResp;
                end
            end
            StRdRes: begin
                if (xfer_abort || xfer_done) state_d = StResp;
            end
            StResp: begin
                if (res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        res_valid  = 1'b0;
        xfer_req   = 1'b0;
        xfer_write = 1'b0;
        xfer_addr  = AddrCtrl;
        xfer_wdata = '0;
        unique case (state_q)
            StIdle: req_ready = 1'b1;
            StWrF0: begin
                xfer_req   = 1'b1;
                xfer_write = 1'b1;
                xfer_addr  = AddrFired0;
                xfer_wdata = fired_q[63:0];
            end
            StWrF1: begin
                xfer_req   = 1'b1;
                xfer_write = 1'b1;
                xfer_addr  = AddrFired1;
                xfer_wdata = {28'b0, fired_q[BoardCells-1:64]};
            end
            StWrShip: begin
                xfer_req   = 1'b1;
                xfer_write = 1'b1;
                xfer_addr  = AddrShips;
                xfer_wdata = {59'b0, ships_q};
            end
            StWrStart: begin
                xfer_req   = 1'b1;
                xfer_write = 1'b1;
                xfer_addr  = AddrCtrl;
                xfer_wdata = 64'd1;
            end
            StPoll: begin
                xfer_req  = 1'b1;
                xfer_addr = AddrCtrl;
            end
            StRdRes: begin
                xfer_req  = 1'b1;
                xfer_addr = AddrResult;
            end
            StResp: res_valid = 1'b1;
            default: ;
        endcase
    end

    // Board snapshot, poll count and result; any abort reports cell 0 with the error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            fired_q     <= '0;
            ships_q     <= '0;
            poll_cnt_q  <= '0;
            res_index_q <= '0;
            res_error_q <= 1'b0;
        end else if (accept) begin
            fired_q     <= fired_in;
            ships_q     <= ships_in;
            poll_cnt_q  <= '0;
            res_index_q <= '0;
            res_error_q <= 1'b0;
        end else if (xfer_abort) begin
            res_index_q <= '0;
            res_error_q <= 1'b1;
        end else if (xfer_done) begin
            if (state_q == StPoll && !poll_done) begin
                poll_cnt_q <= poll_cnt_q + 1'b1;
                if (poll_limit) begin
                    res_index_q <= '0;
                    res_error_q <= 1'b1;
                end
            end else if (state_q == StRdRes) begin
                res_index_q <= result_ok ? ai_rdata[IndexW-1:0] : '0;
                res_error_q <= !result_ok;
            end
        end
    end

endmodule

// File: tb/tb_ai_sequencer.sv
// Randomised bench for ai_sequencer: a behavioural accelerator slave records every bus
// transfer, and each request is checked against the transfer list and timing expected.
module tb_ai_sequencer;
    import ai_sequencer_pkg::*;

    localparam int unsigned StallMax = 8;
    localparam int unsigned PollMax  = 10;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  req_valid, req_ready;
    logic [BoardCells-1:0] fired_in;
    logic [ShipsW-1:0]     ships_in;
    logic                  res_valid, res_ready;
    logic [IndexW-1:0]     res_index;
    logic                  res_error;
    logic [AddrW-1:0]      ai_addr;
    logic                  ai_write, ai_read;
    logic [DataW-1:0]      ai_wdata;
    logic                  ai_waitrequest = 1'b0;
    logic [DataW-1:0]      ai_rdata = '0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;

    // Slave behaviour knobs and recorded transfers.
    int unsigned wr_stall = 0, rd_stall = 0, done_after = 0;
    logic        stuck = 1'b0;
    logic [6:0]  result_val = '0;
    int unsigned poll_seen = 0, stuck_cycles = 0, stall_left = 0;
    logic        in_xfer = 1'b0;
    logic [2:0]  x_addr;
    logic [63:0] x_data;
    logic        x_wr;
    logic [2:0]  log_addr[$];
    logic        log_wr[$];
    logic [63:0] log_data[$];

    ai_sequencer #(
        .STALL_MAX (StallMax),
        .POLL_MAX  (PollMax)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .fired_in       (fired_in),
        .ships_in       (ships_in),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_index      (res_index),
        .res_error      (res_error),
        .ai_addr        (ai_addr),
        .ai_write       (ai_write),
        .ai_read        (ai_read),
        .ai_wdata       (ai_wdata),
        .ai_waitrequest (ai_waitrequest),
        .ai_rdata       (ai_rdata)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [99:0] rand_board();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[99:0];
    endfunction

    // Behavioural slave: decides waitrequest/rdata half a cycle before each rising edge.
    initial forever begin
        @(negedge clock);
        check("rw_exclusive", 64'(ai_write & ai_read), 64'd0);
        ai_rdata = {$urandom, $urandom};
        if (reset) begin
            in_xfer        = 1'b0;
            ai_waitrequest = 1'b0;
        end else if (ai_write || ai_read) begin
            if (!in_xfer) begin
                in_xfer    = 1'b1;
                x_addr     = ai_addr;
                x_data     = ai_wdata;
                x_wr       = ai_write;
                stall_left = ai_write ? wr_stall : rd_stall;
            end else begin
                check("hold_addr", 64'(ai_addr), 64'(x_addr));
                check("hold_data", ai_wdata, x_data);
                check("hold_cmd", 64'(ai_write), 64'(x_wr));
            end
            if (stuck) begin
                ai_waitrequest = 1'b1;
                stuck_cycles++;
            end else if (stall_left > 0) begin
                ai_waitrequest = 1'b1;
                stall_left--;
            end else begin
                ai_waitrequest = 1'b0;
                in_xfer        = 1'b0;
                log_addr.push_back(ai_addr);
                log_wr.push_back(ai_write);
                log_data.push_back(ai_write ? ai_wdata : 64'd0);
                if (ai_read && ai_addr == AddrCtrl) begin
                    poll_seen++;
                    ai_rdata[0] = (poll_seen > done_after);
                end else if (ai_read && ai_addr == AddrResult) begin
                    ai_rdata[6:0] = result_val;
                end
            end
        end else begin
            in_xfer        = 1'b0;
            ai_waitrequest = 1'b0;
        end
    end

    task automatic run_txn(input logic [99:0] f, input logic [4:0] s, input int unsigned ws,
                           input int unsigned rs, input int unsigned da, input logic [6:0] rv,
                           input logic stk);
        int unsigned acc, n_polls, exp_lat, hold;
        logic        done_ok, exp_err;
        logic [6:0]  exp_idx;
        logic [2:0]  ea[$];
        logic        ew[$];
        logic [63:0] ed[$];
        bit          got;

        wr_stall = ws; rd_stall = rs; done_after = da; result_val = rv; stuck = stk;
        poll_seen = 0; stuck_cycles = 0;
        log_addr.delete(); log_wr.delete(); log_data.delete();

        // Expected transfer list and cycle count from the sequencing rules.
        if (stk) begin
            done_ok = 1'b0;
            n_polls = 0;
            exp_lat = StallMax;
            exp_err = 1'b1;
        end else begin
            done_ok = (da < PollMax);
            n_polls = done_ok ? da + 1 : PollMax;
            exp_lat = 4 + 4 * ws + n_polls * (2 + rs) + (done_ok ? 2 + rs : 0);
            exp_err = !done_ok || (rv > 7'd99);
            ea.push_back(AddrFired0); ew.push_back(1'b1); ed.push_back(f[63:0]);
            ea.push_back(AddrFired1); ew.push_back(1'b1); ed.push_back({28'b0, f[99:64]});
            ea.push_back(AddrShips);  ew.push_back(1'b1); ed.push_back({59'b0, s});
            ea.push_back(AddrCtrl);   ew.push_back(1'b1); ed.push_back(64'd1);
            for (int i = 0; i < int'(n_polls); i++) begin
                ea.push_back(AddrCtrl); ew.push_back(1'b0); ed.push_back(64'd0);
            end
            if (done_ok) begin
                ea.push_back(AddrResult); ew.push_back(1'b0); ed.push_back(64'd0);
            end
        end
        exp_idx = exp_err ? 7'd0 : rv;

        fired_in = f; ships_in = s; req_valid = 1'b1; res_ready = 1'b0;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        acc = cyc + 1;
        tick();
        req_valid = 1'b0;
        check("req_ready_busy", 64'(req_ready), 64'd0);
        check("err_cleared", 64'(res_error), 64'd0);

        // Inputs are scrambled while busy; the sequencer must ignore them.
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clock);
            if (res_valid) begin
                got = 1'b1;
            end else begin
                req_valid = 1'($urandom);
                res_ready = 1'($urandom);
                fired_in  = rand_board();
                ships_in  = 5'($urandom);
            end
        end
        req_valid = 1'b0;
        res_ready = 1'b0;
        check("res_valid_seen", 64'(got), 64'd1);
        check("latency", 64'(cyc - acc), 64'(exp_lat));
        check("res_index", 64'(res_index), 64'(exp_idx));
        check("res_error", 64'(res_error), 64'(exp_err));
        if (stk) check("stall_cycles", 64'(stuck_cycles), 64'(StallMax));
        check("xfer_count", 64'(log_addr.size()), 64'(ea.size()));
        for (int i = 0; i < ea.size() && i < log_addr.size(); i++) begin
            check($sformatf("xfer%0d_addr", i), 64'(log_addr[i]), 64'(ea[i]));
            check($sformatf("xfer%0d_write", i), 64'(log_wr[i]), 64'(ew[i]));
            check($sformatf("xfer%0d_data", i), log_data[i], ed[i]);
        end

        hold = $urandom_range(0, 3);
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge clock);
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_index", 64'(res_index), 64'(exp_idx));
            check("hold_error", 64'(res_error), 64'(exp_err));
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("valid_drop", 64'(res_valid), 64'd0);
        check("ready_back", 64'(req_ready), 64'd1);
        check("idle_read", 64'(ai_read), 64'd0);
        check("idle_write", 64'(ai_write), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        reset = 1'b1; req_valid = 1'b0; res_ready = 1'b0; fired_in = '0; ships_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_error", 64'(res_error), 64'd0);
        check("rst_res_index", 64'(res_index), 64'd0);
        check("rst_ai_write", 64'(ai_write), 64'd0);
        check("rst_ai_read", 64'(ai_read), 64'd0);
        check("rst_ai_addr", 64'(ai_addr), 64'd0);
        check("rst_ai_wdata", ai_wdata, 64'd0);

        run_txn('0, 5'b11111, 0, 0, 0, 7'd44, 1'b0);
        run_txn(rand_board(), 5'($urandom), 3, 0, 0, 7'd44, 1'b0);
        run_txn(rand_board(), 5'($urandom), 0, 0, 5, 7'($urandom_range(0, 99)), 1'b0);
        run_txn(rand_board(), 5'($urandom), 0, 0, 0, 7'd17, 1'b1);
        run_txn(rand_board(), 5'($urandom), 0, 0, 0, 7'd120, 1'b0);
        run_txn(rand_board(), 5'($urandom), 0, 1, 1000, 7'd10, 1'b0);

        // Reset while a status poll is on the bus.
        wr_stall = 0; rd_stall = 0; done_after = 1000; stuck = 1'b0;
        fired_in = rand_board(); req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            tick();
            if (ai_read && ai_addr == AddrCtrl) got = 1'b1;
        end
        check("reach_poll", 64'(got), 64'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_read", 64'(ai_read), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd1);
        check("mid_rst_valid", 64'(res_valid), 64'd0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", 64'(req_ready), 64'd1);
        check("post_rst_addr", 64'(ai_addr), 64'd0);

        repeat (20) begin
            run_txn(rand_board(), 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 4), 7'($urandom_range(0, 127)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
